// File: rtl/mdu_pkg.sv
// Shared types, constants and result helpers for the mdu_seq multiply/divide unit.
package mdu_pkg;

    localparam int MDU_XLEN = 64;

    localparam int MDU_MUL  = 0;
    localparam int MDU_DIV  = 1;
    localparam int MDU_DIVU = 2;
    localparam int MDU_REM  = 3;
    localparam int MDU_REMU = 4;

    localparam logic [63:0] MDU_MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [31:0] MDU_MIN32 = 32'h8000_0000;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_e;

    function automatic logic is_onehot5(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    // W operands keep their low half, extended by the signedness of the op.
    function automatic logic [63:0] extend_operand(input logic [63:0] v, input logic word,
                                                   input logic sgn);
        if (!word) return v;
        return sgn ? {{32{v[31]}}, v[31:0]} : {32'd0, v[31:0]};
    endfunction

    function automatic logic [63:0] magnitude(input logic [63:0] v, input logic sgn);
        return (sgn && v[63]) ? (~v + 64'd1) : v;
    endfunction

    function automatic logic signed_ovf(input logic word, input logic [63:0] ext1,
                                        input logic [63:0] ext2);
        logic min_hit;
        min_hit = word ? (ext1 == {32'hFFFF_FFFF, MDU_MIN32}) : (ext1 == MDU_MIN64);
        return min_hit && (ext2 == '1);
    endfunction

    // Operations whose result is known without iterating.
    function automatic logic is_special(input logic [4:0] op, input logic word,
                                        input logic [63:0] ext1, input logic [63:0] ext2);
        logic div_any;
        logic sgn;
        div_any = op[MDU_DIV] | op[MDU_DIVU] | op[MDU_REM] | op[MDU_REMU];
        sgn     = op[MDU_DIV] | op[MDU_REM];
        return is_onehot5(op) &&
               ((div_any && (ext2 == 64'd0)) ||
                (sgn && signed_ovf(word, ext1, ext2)) ||
                (op[MDU_MUL] && ((ext1 == 64'd0) || (ext2 == 64'd0))));
    endfunction

    // Turns raw quotient/accumulator into the architectural result, including
    // sign fix-up, special-case overrides and W sign-extension.
    function automatic logic [63:0] finish_result(input logic [4:0] op, input logic word,
                                                  input logic [63:0] ext1,
                                                  input logic [63:0] ext2,
                                                  input logic [63:0] quo,
                                                  input logic [63:0] acc);
        logic [63:0] res;
        logic        sgn;
        logic        s1;
        logic        s2;
        res = 64'd0;
        sgn = op[MDU_DIV] | op[MDU_REM];
        s1  = sgn & ext1[63];
        s2  = sgn & ext2[63];
        if (!is_onehot5(op)) begin
            res = 64'd0;
        end else if (op[MDU_MUL]) begin
            res = acc;
        end else if (op[MDU_DIV] || op[MDU_DIVU]) begin
            if (ext2 == 64'd0)
                res = '1;
            else if (op[MDU_DIV] && signed_ovf(word, ext1, ext2))
                res = word ? {32'hFFFF_FFFF, MDU_MIN32} : MDU_MIN64;
            else
                res = (s1 ^ s2) ? (~quo + 64'd1) : quo;
        end else begin
            if (ext2 == 64'd0)
                res = ext1;
            else if (op[MDU_REM] && signed_ovf(word, ext1, ext2))
                res = 64'd0;
            else
                res = s1 ? (~acc + 64'd1) : acc;
        end
        if (word) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

endpackage

// File: rtl/mdu_seq_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract.
module mdu_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] divisor,
    input  logic            bit_in,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Keep the subtraction one bit wider so the borrow decides the quotient bit.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[XLEN];
        rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV64 multiply/divide sequencer, one bit per cycle.
// Optional macro MDU_SPECIAL_FAST_EN: divide-by-zero, signed overflow and
// mul-by-zero bypass CALC/FIX and respond the cycle after accept.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic            busy
);

    mdu_state_e      state_q, state_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [4:0]      op_q, op_d;
    logic            word_q, word_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] ext1_q, ext1_d;
    logic [XLEN-1:0] ext2_q, ext2_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic [4:0]      resp_rd_q, resp_rd_d;
    logic            resp_valid_q, resp_valid_d;

    logic            accept;
    logic            in_sgn;
    logic [XLEN-1:0] in_ext1;
    logic [XLEN-1:0] in_ext2;
    logic [XLEN-1:0] in_mag1;
    logic [XLEN-1:0] step_rem;
    logic            step_q;

    assign req_ready  = (state_q == IDLE) & ~flush;
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_rd    = resp_rd_q;

    mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in  (acc_q),
        .divisor (a_q),
        .bit_in  (b_q[XLEN-1]),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Next-state logic: accept and set up operands, iterate, fix up, hold result.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        word_d       = word_q;
        rd_d         = rd_q;
        ext1_d       = ext1_q;
        ext2_d       = ext2_q;
        a_d          = a_q;
        b_d          = b_q;
        acc_d        = acc_q;
        resp_data_d  = resp_data_q;
        resp_rd_d    = resp_rd_q;
        resp_valid_d = 1'b0;

        accept  = req_valid & req_ready;
        in_sgn  = req_op[MDU_DIV] | req_op[MDU_REM];
        in_ext1 = extend_operand(req_src1, req_word, in_sgn);
        in_ext2 = extend_operand(req_src2, req_word, in_sgn);
        in_mag1 = magnitude(in_ext1, in_sgn);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d   = req_op;
                    word_d = req_word;
                    rd_d   = req_rd;
                    ext1_d = in_ext1;
                    ext2_d = in_ext2;
                    cnt_d  = req_word ? 7'd32 : 7'd64;
                    acc_d  = '0;
                    if (req_op[MDU_MUL]) begin
                        a_d = in_ext1;
                        b_d = in_ext2;
                    end else begin
                        a_d = magnitude(in_ext2, in_sgn);
                        b_d = req_word ? {in_mag1[31:0], 32'd0} : in_mag1;
                    end
                    state_d = CALC;
`ifdef MDU_SPECIAL_FAST_EN
                    if (is_special(req_op, req_word, in_ext1, in_ext2)) begin
                        resp_data_d  = finish_result(req_op, req_word, in_ext1, in_ext2,
                                                     '0, '0);
                        resp_rd_d    = req_rd;
                        resp_valid_d = 1'b1;
                        state_d      = DONE;
                    end
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                if (op_q[MDU_MUL]) begin
                    acc_d = acc_q + (b_q[0] ? a_q : '0);
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end else begin
                    acc_d = step_rem;
                    b_d   = {b_q[XLEN-2:0], step_q};
                end
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1) state_d = FIX;
            end
            FIX: begin
                resp_data_d  = finish_result(op_q, word_q, ext1_q, ext2_q, b_q, acc_q);
                resp_rd_d    = rd_q;
                resp_valid_d = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                if (resp_ready) state_d = IDLE;
                else            resp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            word_q       <= 1'b0;
            rd_q         <= '0;
            ext1_q       <= '0;
            ext2_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            resp_data_q  <= '0;
            resp_rd_q    <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            word_q       <= word_d;
            rd_q         <= rd_d;
            ext1_q       <= ext1_d;
            ext2_q       <= ext2_d;
            a_q          <= a_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            resp_valid_q <= resp_valid_d;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed vectors, random ops against an
// arithmetic reference model, and hand-written handshake/flush/reset sequences.
module tb_mdu_seq;

   localparam logic [4:0] OP_MUL  = 5'b00001;
   localparam logic [4:0] OP_DIV  = 5'b00010;
   localparam logic [4:0] OP_DIVU = 5'b00100;
   localparam logic [4:0] OP_REM  = 5'b01000;
   localparam logic [4:0] OP_REMU = 5'b10000;
   localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_op;
   logic        req_word;
   logic [63:0] req_src1;
   logic [63:0] req_src2;
   logic [4:0]  req_rd;
   logic        flush;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_data;
   logic [4:0]  resp_rd;
   logic        busy;

   int checks = 0;
   int errors = 0;

   mdu_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_word   (req_word),
      .req_src1   (req_src1),
      .req_src2   (req_src2),
      .req_rd     (req_rd),
      .flush      (flush),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_rd    (resp_rd),
      .busy       (busy)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string       name;
      logic [4:0]  op;
      logic        word;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
   } vec_t;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, actual, expected);
      end
   endtask

   function automatic logic isOneHot(input logic [4:0] v);
      return $countones(v) == 1;
   endfunction

   // Reference result straight from the M-extension arithmetic rules.
   function automatic logic [63:0] modelResult(input logic [4:0] op, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic signed [63:0] sr;
      logic [63:0] ua;
      logic [63:0] ub;
      logic [63:0] r;
      logic ovf;
      if (!isOneHot(op)) return 64'd0;
      sa = w ? {{32{a[31]}}, a[31:0]} : a;
      sb = w ? {{32{b[31]}}, b[31:0]} : b;
      ua = w ? {32'd0, a[31:0]} : a;
      ub = w ? {32'd0, b[31:0]} : b;
      ovf = !w && (a == MIN64) && (b == '1);
      r = 64'd0;
      case (op)
         OP_MUL:  r = a * b;
         OP_DIV:  begin
            if (sb == 0)  r = '1;
            else if (ovf) r = MIN64;
            else begin sr = sa / sb; r = sr; end
         end
         OP_DIVU: r = (ub == 0) ? '1 : ua / ub;
         OP_REM:  begin
            if (sb == 0)  r = sa;
            else if (ovf) r = 64'd0;
            else begin sr = sa % sb; r = sr; end
         end
         OP_REMU: r = (ub == 0) ? ua : ua % ub;
         default: r = 64'd0;
      endcase
      if (w) r = {{32{r[31]}}, r[31:0]};
      return r;
   endfunction

   function automatic int modelLatency(input logic [4:0] op, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
      logic sp;
      logic [63:0] ma;
      logic [63:0] mb;
      ma = w ? {32'd0, a[31:0]} : a;
      mb = w ? {32'd0, b[31:0]} : b;
      sp = isOneHot(op) &&
           (((op != OP_MUL) && (mb == 0)) ||
            (((op == OP_DIV) || (op == OP_REM)) &&
             (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                : (a == MIN64 && b == '1))) ||
            ((op == OP_MUL) && ((ma == 0) || (mb == 0))));
`ifdef MDU_SPECIAL_FAST_EN
      if (sp) return 1;
`else
      if (sp) return w ? 34 : 66;
`endif
      return w ? 34 : 66;
   endfunction

   // Offer one request, wait for the response, and let it drain if resp_ready is high.
   task automatic applyStimulus(input logic [4:0] op, input logic w, input logic [63:0] a,
                                input logic [63:0] b, input logic [4:0] rd,
                                output int lat, output logic [63:0] data,
                                output logic [4:0] rdo);
      int guard;
      guard = 0;
      while (!req_ready && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      req_valid = 1'b1;
      req_op    = op;
      req_word  = w;
      req_src1  = a;
      req_src2  = b;
      req_rd    = rd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_src1  = $urandom;
      req_src2  = $urandom;
      lat = 1;
      while (!resp_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      data = resp_data;
      rdo  = resp_rd;
      if (resp_valid && resp_ready) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic runAndCheck(input string name, input logic [4:0] op, input logic w,
                              input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] exp, input logic [4:0] rd);
      int          lat;
      logic [63:0] data;
      logic [4:0]  rdo;
      applyStimulus(op, w, a, b, rd, lat, data, rdo);
      checkOutput({name, "_data"}, data, exp);
      checkOutput({name, "_rd"}, {59'd0, rdo}, {59'd0, rd});
      checkOutput({name, "_lat"}, 64'(lat), 64'(modelLatency(op, w, a, b)));
      checkOutput({name, "_idle"}, {63'd0, busy}, 64'd0);
   endtask

   vec_t vecs[$];

   initial begin
      int          lat;
      logic [63:0] data;
      logic [4:0]  rdo;
      logic [63:0] held_data;
      logic [4:0]  held_rd;
      logic        seen;

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_op     = 5'd0;
      req_word   = 1'b0;
      req_src1   = 64'd0;
      req_src2   = 64'd0;
      req_rd     = 5'd0;
      flush      = 1'b0;
      resp_ready = 1'b1;

      // Reset values.
      #12;
      checkOutput("reset_req_ready", {63'd0, req_ready}, 64'd1);
      checkOutput("reset_busy", {63'd0, busy}, 64'd0);
      checkOutput("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
      checkOutput("reset_resp_data", resp_data, 64'd0);
      checkOutput("reset_resp_rd", {59'd0, resp_rd}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors with hand-computed results.
      vecs.push_back('{"mul_neg3x7", OP_MUL, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
                       64'hFFFF_FFFF_FFFF_FFEB});
      vecs.push_back('{"div_m7_2", OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                       64'hFFFF_FFFF_FFFF_FFFD});
      vecs.push_back('{"rem_m7_2", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                       64'hFFFF_FFFF_FFFF_FFFF});
      vecs.push_back('{"divw_ovf", OP_DIV, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF,
                       64'hFFFF_FFFF_8000_0000});
      vecs.push_back('{"remw_ovf", OP_REM, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0});
      vecs.push_back('{"divu_by0", OP_DIVU, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
      vecs.push_back('{"remu_by0", OP_REMU, 1'b0, 64'h1234, 64'd0, 64'h1234});
      vecs.push_back('{"remuw_by0", OP_REMU, 1'b1, 64'hFFFF_FFFF, 64'd0,
                       64'hFFFF_FFFF_FFFF_FFFF});
      vecs.push_back('{"div_min_m1", OP_DIV, 1'b0, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, MIN64});
      vecs.push_back('{"rem_min_m1", OP_REM, 1'b0, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0});
      vecs.push_back('{"divuw_big", OP_DIVU, 1'b1, 64'h5555_0000_FFFF_FFFE, 64'd1,
                       64'hFFFF_FFFF_FFFF_FFFE});
      vecs.push_back('{"mulw_wrap", OP_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2,
                       64'hFFFF_FFFF_FFFF_FFFE});
      vecs.push_back('{"mul_zero", OP_MUL, 1'b0, 64'd0, 64'h1234_5678, 64'd0});
      vecs.push_back('{"remu_big", OP_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, 64'd5});
      vecs.push_back('{"invalid_op", 5'b00011, 1'b0, 64'd100, 64'd7, 64'd0});
      for (int i = 0; i < vecs.size(); i++) begin
         runAndCheck(vecs[i].name, vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b,
                     vecs[i].exp, 5'(i + 1));
      end

      // Randomized operations against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         logic [4:0]  op;
         logic        w;
         logic [63:0] a;
         logic [63:0] b;
         int          mode;
         op   = 5'd1 << $urandom_range(0, 4);
         w    = 1'($urandom_range(0, 1));
         mode = $urandom_range(0, 5);
         a    = {$urandom, $urandom};
         b    = {$urandom, $urandom};
         if (mode == 1) begin
            b = 64'($urandom_range(1, 20));
            if ($urandom_range(0, 1) == 1) b = -b;
         end else if (mode == 2) begin
            b = 64'd0;
         end else if (mode == 3) begin
            a = w ? 64'h8000_0000 : MIN64;
            b = '1;
         end else if (mode == 4) begin
            a = 64'($urandom_range(0, 1000));
            b = 64'($urandom_range(1, 50));
         end
         runAndCheck($sformatf("rand%0d", i), op, w, a, b, modelResult(op, w, a, b),
                     5'($urandom_range(0, 31)));
      end

      // Backpressure: result held stable while writeback stalls.
      resp_ready = 1'b0;
      applyStimulus(OP_DIVU, 1'b0, 64'd100, 64'd7, 5'd9, lat, data, rdo);
      checkOutput("bp_data", data, 64'd14);
      held_data = resp_data;
      held_rd   = resp_rd;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         checkOutput("bp_valid", {63'd0, resp_valid}, 64'd1);
         checkOutput("bp_hold_data", resp_data, held_data);
         checkOutput("bp_hold_rd", {59'd0, resp_rd}, {59'd0, held_rd});
         checkOutput("bp_req_ready", {63'd0, req_ready}, 64'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_idle_busy", {63'd0, busy}, 64'd0);
      checkOutput("bp_idle_ready", {63'd0, req_ready}, 64'd1);
      checkOutput("bp_idle_valid", {63'd0, resp_valid}, 64'd0);

      // Flush in cycle 10 of a div.
      req_valid = 1'b1;
      req_op    = OP_DIV;
      req_word  = 1'b0;
      req_src1  = 64'd1000;
      req_src2  = 64'd3;
      req_rd    = 5'd3;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 2; c <= 10; c++) begin
         @(posedge clk); #1;
      end
      checkOutput("flush_busy_before", {63'd0, busy}, 64'd1);
      flush = 1'b1;
      #1;
      checkOutput("flush_req_ready", {63'd0, req_ready}, 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      checkOutput("flush_idle", {63'd0, busy}, 64'd0);
      seen = 1'b0;
      repeat (80) begin
         @(posedge clk); #1;
         if (resp_valid) seen = 1'b1;
      end
      checkOutput("flush_no_resp", {63'd0, seen}, 64'd0);

      // Flush together with a request: nothing is accepted.
      flush     = 1'b1;
      req_valid = 1'b1;
      req_op    = OP_MUL;
      req_src1  = 64'd5;
      req_src2  = 64'd5;
      @(posedge clk); #1;
      flush     = 1'b0;
      req_valid = 1'b0;
      checkOutput("flush_req_busy", {63'd0, busy}, 64'd0);
      seen = 1'b0;
      repeat (80) begin
         @(posedge clk); #1;
         if (resp_valid) seen = 1'b1;
      end
      checkOutput("flush_req_no_resp", {63'd0, seen}, 64'd0);
      runAndCheck("post_flush_mul", OP_MUL, 1'b0, 64'd6, 64'd7, 64'd42, 5'd17);

      // Asynchronous reset in the middle of an operation.
      req_valid = 1'b1;
      req_op    = OP_MUL;
      req_word  = 1'b0;
      req_src1  = 64'd11;
      req_src2  = 64'd13;
      req_rd    = 5'd21;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
      checkOutput("midrst_ready", {63'd0, req_ready}, 64'd1);
      checkOutput("midrst_valid", {63'd0, resp_valid}, 64'd0);
      checkOutput("midrst_data", resp_data, 64'd0);
      checkOutput("midrst_rd", {59'd0, resp_rd}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      runAndCheck("post_rst_mul", OP_MUL, 1'b0, 64'd11, 64'd13, 64'd143, 5'd22);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
